// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART control front-end.
// Holds the register map (offsets and word-select encoding), the CTRL and
// STATUS bit positions, the default baud divisor and the APB phase decode
// used by the top module. No ports; imported by apb_uart_ctrl and
// uart_baud_div.
package uart_pkg;

  // Byte offsets of the four 32-bit registers
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_DIV    = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // Word select as decoded from PADDR[3:2]
  typedef enum logic [1:0] {
    SEL_DATA   = 2'd0,
    SEL_DIV    = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_STATUS = 2'd3
  } reg_sel_e;

  // APB bus phase as seen in the current cycle
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } apb_phase_e;

  // CTRL register layout
  localparam int CTRL_WIDTH       = 7;
  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_PARITY_EN   = 1;
  localparam int CTRL_PARITY_ODD  = 2;
  localparam int CTRL_STOP2       = 3;
  localparam int CTRL_IE_TX_EMPTY = 4;
  localparam int CTRL_IE_RX_AVAIL = 5;
  localparam int CTRL_IE_ERR      = 6;

  // STATUS register layout
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_FRAME_ERR    = 3;
  localparam int ST_OVERRUN      = 4;
  localparam int ST_RX_LEVEL_LSB = 8;

  // 50 MHz / (115200 * 16) - 1, rounded
  localparam int DIV_RESET_DEFAULT = 26;

endpackage

// File: rtl/uart_baud_div.sv
// Baud-rate generator for the UART shifters.
// A down-counter reloads from the divisor and produces a one-cycle
// 16x-oversampling enable each time it reaches zero; a 4-bit prescaler
// turns every 16th of those into the bit-rate enable.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   enable_i               - run the divider (CTRL.enable)
//   div_i                  - divisor; reload value of the 16x counter
//   restart_i              - reload both counters this cycle (divisor write)
//   baud_tick_o            - one-cycle bit-rate enable
//   baud_tick_16x_o        - one-cycle 16x oversampling enable
module uart_baud_div
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 restart_i,
  output logic                 baud_tick_o,
  output logic                 baud_tick_16x_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           pre_q, pre_d;
  logic                 hold;
  logic                 tick16;

  // While disabled or being restarted the divider sits at its reload point,
  // so the first tick after release comes a full DIV+1 cycles later. The
  // restart input carries the new divisor on div_i in the same cycle, so the
  // reload picks up the value being written rather than the old one.
  always_comb begin
    hold   = !enable_i || restart_i;
    tick16 = !hold && (cnt_q == '0);
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    if (hold) begin
      cnt_d = div_i;
      pre_d = 4'd0;
    end else if (tick16) begin
      cnt_d = div_i;
      pre_d = pre_q + 4'd1;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= DIV_WIDTH'(DIV_RESET);
      pre_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

  // The prescaler counts 16x ticks already taken, so the 16th one lands
  // while it still reads 15.
  assign baud_tick_16x_o = tick16;
  assign baud_tick_o     = tick16 && (pre_q == 4'hF);

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 control front-end for the UART subsystem.
// Decodes a four-register map (DATA, DIV, CTRL, STATUS), inserts a fixed
// number of wait states per access, flags illegal accesses with PSLVERR,
// keeps sticky receiver error flags and raises a maskable level interrupt.
// Drives the TX/RX FIFO handshakes, the baud enables and the frame format.
// Ports:
//   PCLK, PRESETn                          - clock, async active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA       - APB request
//   PREADY/PRDATA/PSLVERR                  - APB response
//   tx_wr_en, tx_wdata, tx_full, tx_level  - TX FIFO push side
//   rx_rd_en, rx_rdata, rx_empty, rx_level - RX FIFO pop side (show-ahead)
//   rx_frame_err, rx_overrun               - receiver error pulses
//   baud_tick, baud_tick_16x               - shifter enables
//   cfg_parity_en, cfg_parity_odd, cfg_stop2 - frame format
//   irq                                    - registered level interrupt
module apb_uart_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_RESET   = DIV_RESET_DEFAULT,
  parameter int FIFO_AW     = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic                  tx_wr_en,
  output logic [7:0]            tx_wdata,
  input  logic                  tx_full,
  input  logic [FIFO_AW:0]      tx_level,
  output logic                  rx_rd_en,
  input  logic [7:0]            rx_rdata,
  input  logic                  rx_empty,
  input  logic [FIFO_AW:0]      rx_level,
  input  logic                  rx_frame_err,
  input  logic                  rx_overrun,
  output logic                  baud_tick,
  output logic                  baud_tick_16x,
  output logic                  cfg_parity_en,
  output logic                  cfg_parity_odd,
  output logic                  cfg_stop2,
  output logic                  irq
);

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

  apb_phase_e            phase;
  reg_sel_e              regSel;
  logic                  waitDone;
  logic                  completion;
  logic                  misaligned;
  logic                  accErr;
  logic                  doWrite;
  logic                  doRead;
  logic                  divWrite;
  logic                  w1cFrame;
  logic                  w1cOverrun;
  logic                  txEmpty;
  logic [DATA_WIDTH-1:0] rdWord;

  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  frameErr_q, frameErr_d;
  logic                  overrun_q, overrun_d;
  logic                  irq_q, irq_d;

  // Only PADDR[3:0] and the low data bits matter; the rest is deliberately
  // left unconnected.
  logic unusedBits;
  assign unusedBits = ^{PADDR, PWDATA};

  // Bus phase decode. Reset is folded in so that, while PRESETn is low, the
  // combinational response and FIFO strobes read as idle even if the master
  // keeps PSEL/PENABLE up.
  always_comb begin
    phase = PH_IDLE;
    if (PRESETn && PSEL) begin
      phase = PENABLE ? PH_ACCESS : PH_SETUP;
    end
  end

  // The counter only ever climbs to WAIT_LIMIT inside an access phase and is
  // zero everywhere else, so an equality test is enough to end the wait.
  always_comb begin
    waitDone  = (waitCnt_q == WAIT_LIMIT);
    waitCnt_d = '0;
    if (phase == PH_ACCESS && !waitDone) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
  end

  assign PREADY     = !(phase == PH_ACCESS && !waitDone);
  assign completion = (phase == PH_ACCESS) && waitDone;

  // Access legality: misaligned offsets always fail; DATA fails when the
  // FIFO on the relevant side cannot take part in the transfer.
  always_comb begin
    regSel     = reg_sel_e'(PADDR[3:2]);
    misaligned = |PADDR[1:0];
    accErr     = misaligned;
    if (!misaligned && regSel == SEL_DATA) begin
      accErr = PWRITE ? tx_full : rx_empty;
    end
  end

  assign doWrite = completion && PWRITE && !accErr;
  assign doRead  = completion && !PWRITE && !accErr;
  assign txEmpty = (tx_level == '0);

  // Read data mux; this is the longest combinational path in the block.
  always_comb begin
    rdWord = '0;
    case (regSel)
      SEL_DATA:   rdWord[7:0] = rx_rdata;
      SEL_DIV:    rdWord[DIV_WIDTH-1:0] = div_q;
      SEL_CTRL:   rdWord[CTRL_WIDTH-1:0] = ctrl_q;
      SEL_STATUS: begin
        rdWord[ST_TX_FULL]   = tx_full;
        rdWord[ST_TX_EMPTY]  = txEmpty;
        rdWord[ST_RX_EMPTY]  = rx_empty;
        rdWord[ST_FRAME_ERR] = frameErr_q;
        rdWord[ST_OVERRUN]   = overrun_q;
        rdWord[ST_RX_LEVEL_LSB +: FIFO_AW+1] = rx_level;
      end
    endcase
  end

  assign PRDATA   = doRead ? rdWord : '0;
  assign PSLVERR  = completion && accErr;
  assign tx_wr_en = doWrite && regSel == SEL_DATA;
  assign tx_wdata = PWDATA[7:0];
  assign rx_rd_en = doRead && regSel == SEL_DATA;

  // Register writes and sticky flags. A receiver pulse in the same cycle as
  // a W1C keeps its flag set, so an error can never be lost to a clear. The
  // interrupt looks at the next-state flags so it follows a pulse or a clear
  // by exactly one cycle.
  always_comb begin
    div_d      = div_q;
    ctrl_d     = ctrl_q;
    divWrite   = 1'b0;
    w1cFrame   = 1'b0;
    w1cOverrun = 1'b0;
    if (doWrite) begin
      case (regSel)
        SEL_DIV: begin
          div_d    = PWDATA[DIV_WIDTH-1:0];
          divWrite = 1'b1;
        end
        SEL_CTRL:   ctrl_d = PWDATA[CTRL_WIDTH-1:0];
        SEL_STATUS: begin
          w1cFrame   = PWDATA[ST_FRAME_ERR];
          w1cOverrun = PWDATA[ST_OVERRUN];
        end
        default: ;
      endcase
    end
    frameErr_d = (frameErr_q && !w1cFrame) || rx_frame_err;
    overrun_d  = (overrun_q && !w1cOverrun) || rx_overrun;
    irq_d = (ctrl_q[CTRL_IE_TX_EMPTY] && txEmpty)
         || (ctrl_q[CTRL_IE_RX_AVAIL] && !rx_empty)
         || (ctrl_q[CTRL_IE_ERR] && (frameErr_d || overrun_d));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      waitCnt_q  <= '0;
      div_q      <= DIV_WIDTH'(DIV_RESET);
      ctrl_q     <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      waitCnt_q  <= waitCnt_d;
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
    end
  end

  assign irq            = irq_q;
  assign cfg_parity_en  = ctrl_q[CTRL_PARITY_EN];
  assign cfg_parity_odd = ctrl_q[CTRL_PARITY_ODD];
  assign cfg_stop2      = ctrl_q[CTRL_STOP2];

  // The divider is handed the next-state divisor so a write reloads the
  // counter with the value being written in the same cycle.
  uart_baud_div #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) uBaudDiv (
    .clk_i           (PCLK),
    .rst_ni          (PRESETn),
    .enable_i        (ctrl_q[CTRL_ENABLE]),
    .div_i           (div_d),
    .restart_i       (divWrite),
    .baud_tick_o     (baud_tick),
    .baud_tick_16x_o (baud_tick_16x)
  );

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed testbench for apb_uart_ctrl with two wait states per access.
// Expected APB responses and TX pushes are queued when a transfer is issued
// and checked when the DUT completes it.
module tb_apb_uart_ctrl;

  logic        PCLK;
  logic        PRESETn;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        tx_wr_en;
  logic [7:0]  tx_wdata;
  logic        tx_full;
  logic [4:0]  tx_level;
  logic        rx_rd_en;
  logic [7:0]  rx_rdata;
  logic        rx_empty;
  logic [4:0]  rx_level;
  logic        rx_frame_err, rx_overrun;
  logic        baud_tick, baud_tick_16x;
  logic        cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] expTxQ[$];

  int checks = 0;
  int errors = 0;
  int pushCount = 0;
  int popCount = 0;
  int lastWaits;
  logic sawEarly;

  apb_uart_ctrl #(
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (32),
    .WAIT_STATES (2),
    .DIV_WIDTH   (16),
    .DIV_RESET   (26),
    .FIFO_AW     (4)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .PADDR          (PADDR),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PWDATA         (PWDATA),
    .PREADY         (PREADY),
    .PRDATA         (PRDATA),
    .PSLVERR        (PSLVERR),
    .tx_wr_en       (tx_wr_en),
    .tx_wdata       (tx_wdata),
    .tx_full        (tx_full),
    .tx_level       (tx_level),
    .rx_rd_en       (rx_rd_en),
    .rx_rdata       (rx_rdata),
    .rx_empty       (rx_empty),
    .rx_level       (rx_level),
    .rx_frame_err   (rx_frame_err),
    .rx_overrun     (rx_overrun),
    .baud_tick      (baud_tick),
    .baud_tick_16x  (baud_tick_16x),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .irq            (irq)
  );

  // 100 MHz clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Watch the FIFO strobes on the falling edge; every push must match the
  // oldest queued byte, and pops are only counted.
  always @(negedge PCLK) begin
    if (PRESETn && tx_wr_en) begin
      pushCount++;
      if (expTxQ.size() == 0) checkOutput("txPush.unexpected", 32'(tx_wdata), 32'h100);
      else checkOutput("txPush.data", 32'(tx_wdata), 32'(expTxQ.pop_front()));
    end
    if (PRESETn && rx_rd_en) popCount++;
  end

  // Runs one APB transfer starting just after a rising edge. The expected
  // response is queued up front and popped when PREADY comes back; the wait
  // cycles are counted and any early response or strobe is flagged.
  // pulseOvr raises rx_overrun for exactly the completion cycle.
  task automatic applyStimulus(input string tag, input logic [3:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [31:0] expRd,
                               input logic expErr, input logic pulseOvr);
    exp_t e;
    bit done = 0;
    e.tag = tag; e.rdata = expRd; e.err = expErr;
    expQ.push_back(e);
    if (wr && addr == 4'h0 && !expErr) expTxQ.push_back(wdata[7:0]);
    lastWaits = 0;
    sawEarly = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #3;
      if (PREADY) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".rdata"}, PRDATA, e.rdata);
        checkOutput({e.tag, ".err"}, 32'(PSLVERR), 32'(e.err));
        if (pulseOvr) rx_overrun = 1'b1;
        done = 1;
      end else begin
        lastWaits++;
        if (PSLVERR || PRDATA != 0 || tx_wr_en || rx_rd_en) sawEarly = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    rx_overrun = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (!done) checkOutput({tag, ".timeout"}, 32'd0, 32'd1);
    checkOutput({tag, ".waits"}, 32'(lastWaits), 32'd2);
    checkOutput({tag, ".early"}, 32'(sawEarly), 32'd0);
  endtask

  // Counts cycles, including the current one, up to the next tick of the
  // chosen kind; also reports whether a 16x tick was present at that moment.
  task automatic cyclesToTick(input bit wantBaud, output int n, output logic coincide);
    bit found = 0;
    n = 0;
    coincide = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      #3;
      n++;
      if (wantBaud ? baud_tick : baud_tick_16x) begin
        found = 1;
        coincide = baud_tick_16x;
      end
      @(posedge PCLK); #1;
    end
    if (!found) checkOutput("tick.timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int base;
    logic co;

    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tx_full = 1'b0; tx_level = 5'd3;
    rx_rdata = 8'h00; rx_empty = 1'b1; rx_level = 5'd0;
    rx_frame_err = 1'b0; rx_overrun = 1'b0;

    // Reset values
    @(posedge PCLK); #1;
    #3;
    checkOutput("rst.PREADY", 32'(PREADY), 32'd1);
    checkOutput("rst.PRDATA", PRDATA, 32'd0);
    checkOutput("rst.PSLVERR", 32'(PSLVERR), 32'd0);
    checkOutput("rst.irq", 32'(irq), 32'd0);
    checkOutput("rst.ticks", {30'd0, baud_tick, baud_tick_16x}, 32'd0);
    checkOutput("rst.strobes", {30'd0, tx_wr_en, rx_rd_en}, 32'd0);
    checkOutput("rst.cfg", {29'd0, cfg_parity_en, cfg_parity_odd, cfg_stop2}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    $display("[TB] register reset values");
    applyStimulus("rdDiv", 4'h4, 1'b0, 32'd0, 32'd26, 1'b0, 1'b0);
    applyStimulus("rdCtrl", 4'h8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("rdStatus", 4'hC, 1'b0, 32'd0, 32'h04, 1'b0, 1'b0);

    $display("[TB] TX push with wait states");
    base = pushCount;
    applyStimulus("txWr", 4'h0, 1'b1, 32'h1A5, 32'd0, 1'b0, 1'b0);
    checkOutput("txWr.pushes", 32'(pushCount - base), 32'd1);

    $display("[TB] DATA and alignment errors");
    base = popCount;
    applyStimulus("rdEmpty", 4'h0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("rdEmpty.pops", 32'(popCount - base), 32'd0);
    tx_full = 1'b1;
    base = pushCount;
    applyStimulus("wrFull", 4'h0, 1'b1, 32'h99, 32'd0, 1'b1, 1'b0);
    checkOutput("wrFull.pushes", 32'(pushCount - base), 32'd0);
    tx_full = 1'b0;
    applyStimulus("rdMisalign", 4'h5, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("wrMisalign", 4'h6, 1'b1, 32'h55, 32'd0, 1'b1, 1'b0);
    applyStimulus("rdDivKept", 4'h4, 1'b0, 32'd0, 32'd26, 1'b0, 1'b0);

    $display("[TB] RX read path");
    rx_rdata = 8'h3C; rx_level = 5'd5; rx_empty = 1'b0;
    applyStimulus("rdStatusRx", 4'hC, 1'b0, 32'd0, 32'h0500, 1'b0, 1'b0);
    base = popCount;
    applyStimulus("rdData", 4'h0, 1'b0, 32'd0, 32'h3C, 1'b0, 1'b0);
    checkOutput("rdData.pops", 32'(popCount - base), 32'd1);
    rx_rdata = 8'h00; rx_level = 5'd0; rx_empty = 1'b1;

    $display("[TB] sticky errors and interrupt");
    applyStimulus("wrIeErr", 4'h8, 1'b1, 32'h40, 32'd0, 1'b0, 1'b0);
    applyStimulus("w1cRace", 4'hC, 1'b1, 32'h10, 32'd0, 1'b0, 1'b1);
    #3;
    checkOutput("w1cRace.irq", 32'(irq), 32'd1);
    @(posedge PCLK); #1;
    applyStimulus("rdStatusOvr", 4'hC, 1'b0, 32'd0, 32'h14, 1'b0, 1'b0);
    rx_frame_err = 1'b1;
    @(posedge PCLK); #1;
    rx_frame_err = 1'b0;
    applyStimulus("rdStatusBoth", 4'hC, 1'b0, 32'd0, 32'h1C, 1'b0, 1'b0);
    applyStimulus("w1cAll", 4'hC, 1'b1, 32'hFF1F, 32'd0, 1'b0, 1'b0);
    #3;
    checkOutput("w1cAll.irq", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    applyStimulus("rdStatusClr", 4'hC, 1'b0, 32'd0, 32'h04, 1'b0, 1'b0);

    $display("[TB] PSEL dropped during a wait");
    base = pushCount;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h0; PWRITE = 1'b1; PWDATA = 32'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    checkOutput("drop.waitLow", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    #3;
    checkOutput("drop.noErr", 32'(PSLVERR), 32'd0);
    repeat (3) begin
      @(posedge PCLK); #1;
    end
    checkOutput("drop.pushes", 32'(pushCount - base), 32'd0);
    applyStimulus("afterDrop", 4'h0, 1'b1, 32'h42, 32'd0, 1'b0, 1'b0);

    $display("[TB] baud divider");
    applyStimulus("wrDiv3", 4'h4, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    applyStimulus("wrEnable", 4'h8, 1'b1, 32'h01, 32'd0, 1'b0, 1'b0);
    cyclesToTick(1'b0, n, co);
    for (int k = 0; k < 3; k++) begin
      cyclesToTick(1'b0, n, co);
      checkOutput("tick16.period", 32'(n), 32'd4);
    end
    cyclesToTick(1'b1, n, co);
    checkOutput("baud.coincide", 32'(co), 32'd1);
    cyclesToTick(1'b1, n, co);
    checkOutput("baud.period", 32'(n), 32'd64);
    checkOutput("baud.coincide2", 32'(co), 32'd1);
    cyclesToTick(1'b0, n, co);
    @(posedge PCLK); #1;
    applyStimulus("divRestart", 4'h4, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    cyclesToTick(1'b0, n, co);
    checkOutput("restart.first16x", 32'(n), 32'd4);
    applyStimulus("divRestart2", 4'h4, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    cyclesToTick(1'b1, n, co);
    checkOutput("restart.firstBaud", 32'(n), 32'd64);
    applyStimulus("wrDiv0", 4'h4, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #3;
      checkOutput("div0.tick16", 32'(baud_tick_16x), 32'd1);
      @(posedge PCLK); #1;
    end

    $display("[TB] reset during a wait state");
    applyStimulus("wrCfg", 4'h8, 1'b1, 32'h1B, 32'd0, 1'b0, 1'b0);
    tx_level = 5'd0;
    @(posedge PCLK); #1;
    #3;
    checkOutput("cfg.bits", {29'd0, cfg_parity_en, cfg_parity_odd, cfg_stop2}, 32'b101);
    checkOutput("cfg.irqTxEmpty", 32'(irq), 32'd1);
    @(posedge PCLK); #1;
    base = pushCount;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h0; PWRITE = 1'b1; PWDATA = 32'h5A;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    checkOutput("abort.waitLow", 32'(PREADY), 32'd0);
    checkOutput("abort.tickBefore", 32'(baud_tick_16x), 32'd1);
    #1;
    PRESETn = 1'b0;
    #2;
    checkOutput("abort.PREADY", 32'(PREADY), 32'd1);
    checkOutput("abort.PSLVERR", 32'(PSLVERR), 32'd0);
    checkOutput("abort.PRDATA", PRDATA, 32'd0);
    checkOutput("abort.strobes", {30'd0, tx_wr_en, rx_rd_en}, 32'd0);
    checkOutput("abort.irq", 32'(irq), 32'd0);
    checkOutput("abort.ticks", {30'd0, baud_tick, baud_tick_16x}, 32'd0);
    checkOutput("abort.cfg", {29'd0, cfg_parity_en, cfg_parity_odd, cfg_stop2}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    tx_level = 5'd3;
    @(posedge PCLK); #1;
    checkOutput("abort.pushes", 32'(pushCount - base), 32'd0);
    applyStimulus("abort.rdDiv", 4'h4, 1'b0, 32'd0, 32'd26, 1'b0, 1'b0);
    applyStimulus("abort.rdCtrl", 4'h8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    checkOutput("txQ.drained", 32'(expTxQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
